// File: rtl/alu_exec.sv
// ALU execute stage: combinational ADD/SUB/AND/OR feeding a 2-entry result FIFO
// with valid/ready handshakes on both sides and a synchronous flush.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_Operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ovf;
    logic             ill;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  logic   wr_ptr, rd_ptr;
  entry_t mem [2];
  entry_t alu, head;
  logic   accept, pop;

  // ALU datapath
  always_comb begin
    alu = '0;
    unique case (ALU_Operation)
      OP_ADD: begin
        alu.res = op_a + op_b;
        alu.ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu.res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu.res = op_a - op_b;
        alu.ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu.res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu.res = op_a & op_b;
      OP_OR:   alu.res = op_a | op_b;
      default: alu.ill = 1'b1;
    endcase
    alu.zero = (alu.res == '0);
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  // flush masks both handshakes so nothing is counted that cycle
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    state_d = state_q;
    if (flush) state_d = EMPTY;
    else begin
      unique case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE:     if (accept && !pop) state_d = TWO;
                 else if (pop && !accept) state_d = EMPTY;
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (accept) wr_ptr <= ~wr_ptr;
        if (pop)    rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Storage needs no reset: reads are gated by out_valid
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= alu;
  end

  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign result     = head.res;
  assign zero       = head.zero;
  assign overflow   = head.ovf;
  assign illegal_op = head.ill;

endmodule
